// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add controller sequencing one full-adder cell, LSB first
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the i_sub port.

module serial_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-2:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_s;
  logic               w_cout;
  logic [WIDTH-1:0]   w_sum_next;
  logic [WIDTH-1:0]   w_b_load;

  // Subtract is A + ~B + Cin, so only B needs conditioning at capture.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = i_sub ? ~i_b : i_b;
`else
  assign w_b_load = i_b;
`endif

  serial_adder_fa u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // Partial sums accumulate in r_sum; o_s is only written with the completed word.
  assign w_sum_next = {w_s, r_sum};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_s     <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= w_b_load;
            r_carry <= i_cin;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_sum   <= w_sum_next[WIDTH-1:1];
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            o_s     <= w_sum_next;
            o_cout  <= w_cout;
            o_ovf   <= r_carry ^ w_cout;
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl against an arithmetic reference model

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         i_sub;
`endif
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_s;
  logic         o_cout;
  logic         o_ovf;

  int n_pass  = 0;
  int n_total = 0;

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (i_sub),
`endif
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_s     (o_s),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, output logic [W-1:0] s, output logic c,
                                output logic o);
    longint u;
    int     r;
    int     sa;
    int     sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      u = longint'(a) + longint'(b) + longint'(cin);
      r = sa + sb + int'(cin);
    end else begin
      u = longint'(a) + (longint'(2**W) - 1 - longint'(b)) + longint'(cin);
      r = sa - sb - (1 - int'(cin));
    end
    s = u[W-1:0];
    c = u[W];
    o = (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input string tag);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    logic [W-1:0] s_before;
    logic         partial_bad;
    int           lat;
    int           busy_cnt;
    model(a, b, cin, sub, es, ec, eo);
    @(negedge i_clk);
    i_a = a; i_b = b; i_cin = cin; i_start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    i_sub = sub;
`endif
    @(negedge i_clk);
    i_start  = 1'b0;
    s_before = o_s;
    busy_cnt = o_busy ? 1 : 0;
    partial_bad = 1'b0;
    lat = 0;
    while (!o_done && lat < 4 * W) begin
      i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'($urandom);
      i_start = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      i_sub = 1'($urandom);
`endif
      @(negedge i_clk);
      lat = lat + 1;
      if (o_busy) busy_cnt = busy_cnt + 1;
      if (!o_done && o_s !== s_before) partial_bad = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(W));
    check({tag, "_s"}, 64'(o_s), 64'(es));
    check({tag, "_cout"}, 64'(o_cout), 64'(ec));
    check({tag, "_ovf"}, 64'(o_ovf), 64'(eo));
    check({tag, "_no_partial"}, 64'(partial_bad), 64'(0));
    i_start = 1'b0;
    @(negedge i_clk);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    check({tag, "_done_pulse"}, 64'(o_done), 64'(0));
    check({tag, "_busy_low"}, 64'(o_busy), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic         hold_bad;
    logic         done_seen;
    int           lat;

    i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    i_sub = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    check("reset_busy", 64'(o_busy), 64'(0));
    check("reset_done", 64'(o_done), 64'(0));
    check("reset_s", 64'(o_s), 64'(0));
    check("reset_cout", 64'(o_cout), 64'(0));
    check("reset_ovf", 64'(o_ovf), 64'(0));
    i_rst = 1'b0;

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1");
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, "7f_cin");
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "5a_3c");

    hold_bad = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_s !== 8'h96 || o_cout !== 1'b0 || o_ovf !== 1'b1 || o_done !== 1'b0) hold_bad = 1'b1;
    end
    check("hold_20_idle", 64'(hold_bad), 64'(0));
    check("hold_s", 64'(o_s), 64'h96);

    // Start held high: the DONE-cycle request must be ignored.
    @(negedge i_clk);
    i_a = 8'h01; i_b = 8'h02; i_cin = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    check("b2b_busy", 64'(o_busy), 64'(1));
    lat = 0;
    while (!o_done && lat < 4 * W) begin
      i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'($urandom);
      @(negedge i_clk);
      lat = lat + 1;
    end
    check("b2b_first_latency", 64'(lat), 64'(W));
    check("b2b_first_s", 64'(o_s), 64'h03);
    i_a = 8'h40; i_b = 8'h23; i_cin = 1'b1;
    @(negedge i_clk);
    check("b2b_gap_busy", 64'(o_busy), 64'(0));
    check("b2b_gap_done", 64'(o_done), 64'(0));
    @(negedge i_clk);
    check("b2b_second_accept", 64'(o_busy), 64'(1));
    i_start = 1'b0;
    lat = 0;
    while (!o_done && lat < 4 * W) begin
      @(negedge i_clk);
      lat = lat + 1;
    end
    check("b2b_second_latency", 64'(lat), 64'(W));
    check("b2b_second_s", 64'(o_s), 64'h64);

    // Reset abort at bit 3.
    repeat (2) @(negedge i_clk);
    i_a = 8'h11; i_b = 8'h22; i_cin = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("abort_busy", 64'(o_busy), 64'(0));
    check("abort_s", 64'(o_s), 64'(0));
    check("abort_done", 64'(o_done), 64'(0));
    done_seen = 1'b0;
    repeat (W + 2) begin
      @(negedge i_clk);
      if (o_done || o_busy) done_seen = 1'b1;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));
    run_op(8'h11, 8'h22, 1'b0, 1'b0, "abort_rerun");

    // Start together with reset is not accepted.
    i_start = 1'b1; i_rst = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_rst = 1'b0;
    @(negedge i_clk);
    check("start_rst_same_edge", 64'(o_busy), 64'(0));

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b1, "sub_5_7");
    run_op(8'h80, 8'h01, 1'b1, 1'b1, "sub_80_1");
`endif

    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
